// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter with optional return-address stack (macro PC_RAS_EN)
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter int               OFFSET_W     = 8,
    parameter int               INC          = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                call,
    input  logic [WIDTH-1:0]    bus,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_next,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_ovf,
    output logic                ras_unf
);
    localparam logic [1:0]       MODE_INC    = 2'b00;
    localparam logic [1:0]       MODE_JUMP   = 2'b01;
    localparam logic [1:0]       MODE_BRANCH = 2'b10;
    localparam logic [1:0]       MODE_RETURN = 2'b11;
    localparam logic [WIDTH-1:0] INC_W       = WIDTH'(INC);

    logic [WIDTH-1:0] offset_sext;
    logic [WIDTH-1:0] return_target;

    assign offset_sext = {{(WIDTH-OFFSET_W){offset[OFFSET_W-1]}}, offset};

    // Select the next fetch address; all arithmetic wraps modulo 2^WIDTH
    always_comb begin
        pc_next = pc;
        case (mode)
            MODE_INC:    pc_next = pc + INC_W;
            MODE_JUMP:   pc_next = bus;
            MODE_BRANCH: pc_next = pc + offset_sext;
            MODE_RETURN: pc_next = return_target;
            default:     pc_next = pc;
        endcase
    end

    // PC register: advances only when enabled, stalls otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (en) begin
            pc <= pc_next;
        end
    end

`ifdef PC_RAS_EN
    localparam int             PTR_W      = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Calls only ride on JUMP/BRANCH; RETURN is the only pop
    assign do_push       = en && call && (mode == MODE_JUMP || mode == MODE_BRANCH);
    assign do_pop        = en && (mode == MODE_RETURN);
    assign ras_empty     = (count == '0);
    assign ras_full      = (count == FULL_COUNT);
    assign return_target = ras_empty ? pc : stack[top];

    // Stack storage: circular, so a push when full overwrites the oldest slot
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[top + PTR_W'(1)] <= pc + INC_W;
        end
    end

    // Stack pointer, occupancy and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top     <= '0;
            count   <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            if (do_push) begin
                top <= top + PTR_W'(1);
                if (!ras_full) begin
                    count <= count + (PTR_W+1)'(1);
                end
            end else if (do_pop && !ras_empty) begin
                top   <= top - PTR_W'(1);
                count <= count - (PTR_W+1)'(1);
            end
            if (do_push && ras_full) begin
                ras_ovf <= 1'b1;
            end else if (err_clr) begin
                ras_ovf <= 1'b0;
            end
            if (do_pop && ras_empty) begin
                ras_unf <= 1'b1;
            end else if (err_clr) begin
                ras_unf <= 1'b0;
            end
        end
    end
`else
    logic unused_ras_inputs;

    // Without a stack, RETURN simply holds and the status outputs are fixed
    assign return_target     = pc;
    assign ras_empty         = 1'b1;
    assign ras_full          = 1'b0;
    assign ras_ovf           = 1'b0;
    assign ras_unf           = 1'b0;
    assign unused_ras_inputs = call ^ err_clr;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer (both PC_RAS_EN builds)
module tb_pc_sequencer;
    localparam int D = 4;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        call;
    logic [15:0] bus;
    logic [7:0]  offset;
    logic        err_clr;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;

    pc_sequencer #(
        .WIDTH(16), .OFFSET_W(8), .INC(1), .RESET_VECTOR(16'h0000), .RAS_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .call(call), .bus(bus),
        .offset(offset), .err_clr(err_clr), .pc(pc), .pc_next(pc_next),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: PC as a number, return stack as a queue (back = top)
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    bit          m_ovf;
    bit          m_unf;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        call;
        logic [15:0] bus;
        logic [7:0]  offset;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_next(input logic [1:0] md, input logic [15:0] b,
                                           input logic [7:0] o);
        case (md)
            2'd0:    return 16'(int'(m_pc) + 1);
            2'd1:    return b;
            2'd2:    return 16'(int'(m_pc) + int'($signed(o)));
            default: return (RAS && m_stack.size() > 0) ? m_stack[$] : m_pc;
        endcase
    endfunction

    task automatic m_reset();
        m_pc = 16'h0000;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic m_step(input logic e, input logic [1:0] md, input logic c,
                          input logic [15:0] b, input logic [7:0] o, input logic ec);
        logic [15:0] nxt;
        bit ovf_ev;
        bit unf_ev;
        nxt = m_next(md, b, o);
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (e) begin
            if (RAS && c && (md == 2'd1 || md == 2'd2)) begin
                if (m_stack.size() == D) begin
                    void'(m_stack.pop_front());
                    ovf_ev = 1'b1;
                end
                m_stack.push_back(16'(int'(m_pc) + 1));
            end
            if (RAS && md == 2'd3) begin
                if (m_stack.size() == 0) unf_ev = 1'b1;
                else void'(m_stack.pop_back());
            end
            m_pc = nxt;
        end
        if (ovf_ev) m_ovf = 1'b1;
        else if (ec) m_ovf = 1'b0;
        if (unf_ev) m_unf = 1'b1;
        else if (ec) m_unf = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_empty"}, ras_empty, m_stack.size() == 0);
        chk({tag, "_full"}, ras_full, m_stack.size() == D);
        chk({tag, "_ovf"}, ras_ovf, m_ovf);
        chk({tag, "_unf"}, ras_unf, m_unf);
    endtask

    // Drive one cycle of inputs, check pc_next before the edge and state after it
    task automatic step(input logic e, input logic [1:0] md, input logic c,
                        input logic [15:0] b, input logic [7:0] o, input logic ec);
        en = e; mode = md; call = c; bus = b; offset = o; err_clr = ec;
        #1;
        chk("pc_next", pc_next, m_next(md, b, o));
        @(posedge clk);
        m_step(e, md, c, b, o, ec);
        #1;
        check_state("step");
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'd1, 1'b0, 16'hFFFF, 8'h00, 16'hFFFF};
        tbl[1] = '{1'b1, 2'd0, 1'b0, 16'h0000, 8'h00, 16'h0000};
        tbl[2] = '{1'b1, 2'd1, 1'b0, 16'h0002, 8'h00, 16'h0002};
        tbl[3] = '{1'b1, 2'd2, 1'b0, 16'h0000, 8'hFC, 16'hFFFE};
        tbl[4] = '{1'b1, 2'd1, 1'b0, 16'h0010, 8'h00, 16'h0010};
        tbl[5] = '{1'b1, 2'd2, 1'b0, 16'h0000, 8'h7F, 16'h008F};
        tbl[6] = '{1'b1, 2'd2, 1'b0, 16'h0000, 8'h80, 16'h000F};
        tbl[7] = '{1'b0, 2'd1, 1'b0, 16'h1234, 8'h00, 16'h000F};
        tbl[8] = '{1'b1, 2'd1, 1'b0, 16'h0010, 8'h00, 16'h0010};

        rst = 1'b1; en = 1'b0; mode = 2'd0; call = 1'b0; bus = '0; offset = '0; err_clr = 1'b0;
        m_reset();
        #12;
        check_state("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset from the middle of a run
        step(1'b1, 2'd1, 1'b0, 16'h0123, 8'h00, 1'b0);
        chk("pre_rst_pc", pc, 16'h0123);
        rst = 1'b1;
        #1;
        m_reset();
        chk("async_rst_pc", pc, 16'h0000);
        check_state("async_rst");
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("inc3_pc", pc, 16'h0003);

        // Wrap-around, branches and stall from the vector table
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].en, tbl[i].mode, tbl[i].call, tbl[i].bus, tbl[i].offset, 1'b0);
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
        end

        // Call then return
        step(1'b1, 2'd1, 1'b1, 16'h0200, 8'h00, 1'b0);
        chk("call_pc", pc, 16'h0200);
        step(1'b1, 2'd3, 1'b0, 16'h0000, 8'h00, 1'b0);
`ifdef PC_RAS_EN
        chk("ret_pc", pc, 16'h0011);
        chk("ret_empty", ras_empty, 1'b1);
`else
        chk("ret_hold_pc", pc, 16'h0200);
        chk("ret_flags", {ras_empty, ras_full, ras_ovf, ras_unf}, 4'b1000);
`endif

        // Five nested calls, then drain one beyond empty
        for (int k = 1; k <= 5; k++) step(1'b1, 2'd1, 1'b1, 16'(k * 256), 8'h00, 1'b0);
`ifdef PC_RAS_EN
        chk("nest_full", ras_full, 1'b1);
        chk("nest_ovf", ras_ovf, 1'b1);
`endif
        for (int k = 4; k >= 1; k--) begin
            step(1'b1, 2'd3, 1'b0, 16'h0000, 8'h00, 1'b0);
`ifdef PC_RAS_EN
            chk($sformatf("pop%0d_pc", k), pc, 16'(k * 256 + 1));
`else
            chk($sformatf("pop%0d_pc", k), pc, 16'h0500);
`endif
        end
        step(1'b1, 2'd3, 1'b0, 16'h0000, 8'h00, 1'b0);
`ifdef PC_RAS_EN
        chk("unf_pc", pc, 16'h0101);
        chk("unf_flag", ras_unf, 1'b1);
`endif
        step(1'b0, 2'd0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("clr_flags", {ras_ovf, ras_unf}, 2'b00);

        // Stall with a pending call, then release once
        for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 1'b1, 16'h0777, 8'h00, 1'b0);
        chk("stall_pc", pc, m_pc);
        step(1'b1, 2'd1, 1'b1, 16'h0777, 8'h00, 1'b0);
        chk("release_pc", pc, 16'h0777);
`ifdef PC_RAS_EN
        chk("release_empty", ras_empty, 1'b0);
`else
        chk("release_empty", ras_empty, 1'b1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 8, 2'($urandom), 1'($urandom),
                 16'($urandom), 8'($urandom), $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
